// File: rtl/output_pipe.sv
// output_pipe: packs core-wide result vectors into narrow DMA AXI-Stream beats
// with tlast framing. A single holding register takes up backpressure from the
// DMA. It can accept a new vector in the same cycle that it sends the last beat
// of the current one, so a steady stream of vectors has no bubbles.
// Optional build macro: OUTPUT_PIPE_RELU_EN clamps negative words to zero
// when the holding register is loaded.
module output_pipe #(
   parameter int DATA_WIDTH       = 16,
   parameter int CONV_UNITS       = 8,
   parameter int OUTPUT_DMA_WIDTH = 64
) (
   input  logic                             aclk,
   input  logic                             areset,
   input  logic [CONV_UNITS*DATA_WIDTH-1:0] S_AXIS_tdata,
   input  logic                             S_AXIS_tvalid,
   input  logic                             S_AXIS_tlast,
   output logic                             S_AXIS_tready,
   output logic [OUTPUT_DMA_WIDTH-1:0]      M_AXIS_tdata,
   output logic                             M_AXIS_tvalid,
   output logic                             M_AXIS_tlast,
   input  logic                             M_AXIS_tready,
   output logic                             frame_done
);

   localparam int OUT_NUM = OUTPUT_DMA_WIDTH / DATA_WIDTH;
   localparam int BEATS   = CONV_UNITS / OUT_NUM;
   localparam int VEC_W   = CONV_UNITS * DATA_WIDTH;
   localparam int IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   generate
      if ((OUTPUT_DMA_WIDTH % DATA_WIDTH) != 0 || (CONV_UNITS % OUT_NUM) != 0 || BEATS < 1) begin : g_bad_cfg
         $error("output_pipe: CONV_UNITS must be a whole multiple of OUTPUT_DMA_WIDTH/DATA_WIDTH");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 last_q;
   logic                 load;
   logic                 last_beat;
   logic                 vld_p0;
   logic                 frame_done_q;
   logic [VEC_W-1:0]     hold_p0;

   // Optional ReLU: words are treated as two's complement, negative words become zero
   function automatic logic [VEC_W-1:0] clamp_vec(input logic [VEC_W-1:0] v);
      logic [VEC_W-1:0] r;
      r = v;
`ifdef OUTPUT_PIPE_RELU_EN
      for (int j = 0; j < CONV_UNITS; j++) begin
         if ($signed(v[j*DATA_WIDTH +: DATA_WIDTH]) < 0)
            r[j*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
`endif
      return r;
   endfunction

   assign last_beat = (idx_q == LAST_IDX);
   assign vld_p0    = (state_q == SEND);

   // Next-state, beat index and handshake control
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      load          = 1'b0;
      S_AXIS_tready = 1'b0;
      case (state_q)
         IDLE: begin
            S_AXIS_tready = 1'b1;
            if (S_AXIS_tvalid) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            // Only the final beat can make room for the next vector. This is the one combinational ready path.
            S_AXIS_tready = last_beat && M_AXIS_tready;
            if (M_AXIS_tready) begin
               if (!last_beat) begin
                  idx_d = idx_q + 1'b1;
               end else if (S_AXIS_tvalid) begin
                  load  = 1'b1;
                  idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state: FSM, beat index, frame flag and frame_done pulse
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         frame_done_q <= vld_p0 && M_AXIS_tready && M_AXIS_tlast;
         if (load)
            last_q <= S_AXIS_tlast;
      end
   end

   // ---- stage p0: holding register (data path, not reset) ----
   always_ff @(posedge aclk) begin
      if (load)
         hold_p0 <= clamp_vec(S_AXIS_tdata);
   end

   // Select the current beat's slice of the holding register
   always_comb begin
      M_AXIS_tdata = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (idx_q == IDX_W'(b))
            M_AXIS_tdata = hold_p0[b*OUTPUT_DMA_WIDTH +: OUTPUT_DMA_WIDTH];
      end
   end

   assign M_AXIS_tvalid = vld_p0;
   assign M_AXIS_tlast  = vld_p0 && last_q && last_beat;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_output_pipe.sv
// Directed bench for output_pipe: the default 2-beat build (u0) and a 1-beat
// pass-through build (u1, OUTPUT_DMA_WIDTH=128).
module tb_output_pipe;

   logic         aclk = 1'b0;
   logic         areset;

   logic [127:0] a_s_tdata;
   logic         a_s_tvalid, a_s_tlast, a_s_tready;
   logic [63:0]  a_m_tdata;
   logic         a_m_tvalid, a_m_tlast, a_m_tready, a_fd;

   logic [127:0] b_s_tdata;
   logic         b_s_tvalid, b_s_tlast, b_s_tready;
   logic [127:0] b_m_tdata;
   logic         b_m_tvalid, b_m_tlast, b_m_tready, b_fd;

   int compared = 0;
   int mismatched = 0;

   always #5 aclk = ~aclk;

   output_pipe u0 (
      .aclk(aclk), .areset(areset),
      .S_AXIS_tdata(a_s_tdata), .S_AXIS_tvalid(a_s_tvalid), .S_AXIS_tlast(a_s_tlast),
      .S_AXIS_tready(a_s_tready),
      .M_AXIS_tdata(a_m_tdata), .M_AXIS_tvalid(a_m_tvalid), .M_AXIS_tlast(a_m_tlast),
      .M_AXIS_tready(a_m_tready), .frame_done(a_fd)
   );

   output_pipe #(.DATA_WIDTH(16), .CONV_UNITS(8), .OUTPUT_DMA_WIDTH(128)) u1 (
      .aclk(aclk), .areset(areset),
      .S_AXIS_tdata(b_s_tdata), .S_AXIS_tvalid(b_s_tvalid), .S_AXIS_tlast(b_s_tlast),
      .S_AXIS_tready(b_s_tready),
      .M_AXIS_tdata(b_m_tdata), .M_AXIS_tvalid(b_m_tvalid), .M_AXIS_tlast(b_m_tlast),
      .M_AXIS_tready(b_m_tready), .frame_done(b_fd)
   );

   // 8 words base, base+1, ... base+7, word 0 in the LSBs
   function automatic logic [127:0] mkvec(input int base);
      logic [127:0] r;
      for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(base + j);
      return r;
   endfunction

   // Expected 64-bit beat h of the vector built by mkvec(base)
   function automatic logic [63:0] beat(input int base, input int h);
      logic [63:0] r;
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(base + 4*h + i);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge
   task automatic tick;
      @(posedge aclk);
      #2;
   endtask

   int nxt;
   logic [127:0] relu_in;
   logic [63:0]  relu_b0, relu_b1;

   initial begin
      areset = 1'b1;
      a_s_tdata = '0; a_s_tvalid = 0; a_s_tlast = 0; a_m_tready = 1;
      b_s_tdata = '0; b_s_tvalid = 0; b_s_tlast = 0; b_m_tready = 1;
      tick; tick;
      areset = 1'b0;
      tick;
      #1;
      chk("rst_tvalid", a_m_tvalid, 0);
      chk("rst_tlast", a_m_tlast, 0);
      chk("rst_fd", a_fd, 0);
      chk("rst_sready", a_s_tready, 1);
      chk("rst_b_tvalid", b_m_tvalid, 0);

      // Single vector with tlast
      a_s_tdata = mkvec(0); a_s_tvalid = 1; a_s_tlast = 1; a_m_tready = 1;
      #1 chk("sv_idle_ready", a_s_tready, 1);
      tick;
      a_s_tvalid = 0; a_s_tlast = 0;
      #1;
      chk("sv_b0_valid", a_m_tvalid, 1);
      chk("sv_b0_data", a_m_tdata, 64'h0003_0002_0001_0000);
      chk("sv_b0_last", a_m_tlast, 0);
      chk("sv_b0_sready", a_s_tready, 0);
      tick; #1;
      chk("sv_b1_data", a_m_tdata, 64'h0007_0006_0005_0004);
      chk("sv_b1_last", a_m_tlast, 1);
      chk("sv_b1_sready", a_s_tready, 1);
      chk("sv_b1_fd", a_fd, 0);
      tick; #1;
      chk("sv_end_valid", a_m_tvalid, 0);
      chk("sv_fd_pulse", a_fd, 1);
      tick; #1;
      chk("sv_fd_clear", a_fd, 0);

      // Streaming: four vectors, the last with tlast
      a_s_tdata = mkvec(16); a_s_tvalid = 1; a_s_tlast = 0;
      tick;
      nxt = 1;
      for (int c = 0; c < 8; c++) begin
         if (nxt < 4) begin
            a_s_tdata = mkvec((nxt + 1) * 16); a_s_tvalid = 1; a_s_tlast = (nxt == 3);
         end else begin
            a_s_tvalid = 0; a_s_tlast = 0;
         end
         #1;
         chk($sformatf("st_valid%0d", c), a_m_tvalid, 1);
         chk($sformatf("st_data%0d", c), a_m_tdata, beat((c/2 + 1) * 16, c % 2));
         chk($sformatf("st_last%0d", c), a_m_tlast, (c == 7));
         chk($sformatf("st_sready%0d", c), a_s_tready, (c % 2 == 1));
         chk($sformatf("st_fd%0d", c), a_fd, 0);
         tick;
         if (c % 2 == 1 && nxt < 4) nxt++;
      end
      #1;
      chk("st_end_valid", a_m_tvalid, 0);
      chk("st_fd_pulse", a_fd, 1);
      tick; #1;
      chk("st_fd_clear", a_fd, 0);

      // Backpressure: sink ready 1,0,0,1
      a_s_tdata = mkvec(80); a_s_tvalid = 1; a_s_tlast = 1;
      tick;
      a_s_tvalid = 0; a_s_tlast = 0; a_m_tready = 1;
      #1 chk("bp_b0_data", a_m_tdata, beat(80, 0));
      tick;
      a_m_tready = 0;
      #1;
      chk("bp_stall1_data", a_m_tdata, beat(80, 1));
      chk("bp_stall1_last", a_m_tlast, 1);
      chk("bp_stall1_sready", a_s_tready, 0);
      tick;
      #1;
      chk("bp_stall2_valid", a_m_tvalid, 1);
      chk("bp_stall2_data", a_m_tdata, beat(80, 1));
      chk("bp_stall2_last", a_m_tlast, 1);
      chk("bp_stall2_fd", a_fd, 0);
      a_m_tready = 1;
      #1 chk("bp_go_sready", a_s_tready, 1);
      tick; #1;
      chk("bp_end_valid", a_m_tvalid, 0);
      chk("bp_fd_pulse", a_fd, 1);
      tick;

      // Reset mid-frame, after beat 0 of a tlast vector
      a_s_tdata = mkvec(96); a_s_tvalid = 1; a_s_tlast = 1;
      tick;
      a_s_tvalid = 0; a_s_tlast = 0;
      tick;
      a_m_tready = 0; areset = 1;
      #1 chk("rm_pre_last", a_m_tlast, 1);
      tick;
      areset = 0; a_m_tready = 1;
      #1;
      chk("rm_valid", a_m_tvalid, 0);
      chk("rm_sready", a_s_tready, 1);
      chk("rm_last", a_m_tlast, 0);
      chk("rm_fd", a_fd, 0);
      a_s_tdata = mkvec(112); a_s_tvalid = 1; a_s_tlast = 0;
      tick;
      a_s_tvalid = 0;
      #1;
      chk("rm_fd2", a_fd, 0);
      chk("rm_new_b0", a_m_tdata, beat(112, 0));
      tick; #1;
      chk("rm_new_b1", a_m_tdata, beat(112, 1));
      chk("rm_new_last", a_m_tlast, 0);
      tick; #1;
      chk("rm_new_fd", a_fd, 0);
      chk("rm_new_end", a_m_tvalid, 0);

      // ReLU vectors
      relu_in = '0;
      relu_in[63:0]   = 64'h0000_FFFF_7FFF_8001;
      relu_in[127:64] = 64'hC000_1234_8000_0005;
`ifdef OUTPUT_PIPE_RELU_EN
      relu_b0 = 64'h0000_0000_7FFF_0000;
      relu_b1 = 64'h0000_1234_0000_0005;
`else
      relu_b0 = 64'h0000_FFFF_7FFF_8001;
      relu_b1 = 64'hC000_1234_8000_0005;
`endif
      a_s_tdata = relu_in; a_s_tvalid = 1; a_s_tlast = 0;
      tick;
      a_s_tvalid = 0;
      #1 chk("relu_b0", a_m_tdata, relu_b0);
      tick;
      #1 chk("relu_b1", a_m_tdata, relu_b1);
      tick;

      // One beat per vector (u1): vector every cycle, sink ready
      b_s_tdata = mkvec(128); b_s_tvalid = 1; b_s_tlast = 0; b_m_tready = 1;
      tick;
      for (int c = 0; c < 3; c++) begin
         if (c < 2) begin
            b_s_tdata = mkvec(128 + 16*(c + 1)); b_s_tvalid = 1; b_s_tlast = (c == 1);
         end else begin
            b_s_tvalid = 0; b_s_tlast = 0;
         end
         #1;
         chk($sformatf("p1_valid%0d", c), b_m_tvalid, 1);
         chk($sformatf("p1_data%0d", c), b_m_tdata, mkvec(128 + 16*c));
         chk($sformatf("p1_last%0d", c), b_m_tlast, (c == 2));
         chk($sformatf("p1_sready%0d", c), b_s_tready, 1);
         tick;
      end
      #1;
      chk("p1_end_valid", b_m_tvalid, 0);
      chk("p1_fd", b_fd, 1);
      b_s_tdata = mkvec(176); b_s_tvalid = 1; b_s_tlast = 0;
      tick;
      b_s_tdata = mkvec(192); b_m_tready = 0;
      #1;
      chk("p1_stall_sready", b_s_tready, 0);
      chk("p1_stall_data", b_m_tdata, mkvec(176));
      tick;
      #1;
      chk("p1_stall2_data", b_m_tdata, mkvec(176));
      chk("p1_stall2_valid", b_m_tvalid, 1);
      b_m_tready = 1;
      #1 chk("p1_go_sready", b_s_tready, 1);
      tick;
      b_s_tvalid = 0;
      #1 chk("p1_next_data", b_m_tdata, mkvec(192));
      tick;
      #1 chk("p1_final_valid", b_m_tvalid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/output_pipe.md
# output_pipe

Serializes the wide per-cycle result vector of the convolution engine into the narrow output DMA AXI-Stream. It is the egress counterpart of `input_pipe`: that block unpacks DMA beats into core-wide vectors, and this block packs core-wide vectors back into DMA beats with correct `tlast` framing. It sits between the conv/maxpool result stage and the S2MM DMA, and it absorbs DMA backpressure with a single holding register.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of one result word.
- `CONV_UNITS`, 8: number of result words per input beat.
- `OUTPUT_DMA_WIDTH`, 64: output stream width. `OUT_NUM = OUTPUT_DMA_WIDTH/DATA_WIDTH`, `BEATS = CONV_UNITS/OUT_NUM`. `CONV_UNITS % OUT_NUM == 0` and `BEATS >= 1` are required; elaboration fails otherwise.

Ports:
- `aclk`, in, 1: clock.
- `areset`, in, 1: reset, synchronous and active-high.
- `S_AXIS_tdata`, in, `CONV_UNITS*DATA_WIDTH`: result vector. Word j sits at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `S_AXIS_tvalid`, in, 1.
- `S_AXIS_tlast`, in, 1: marks the last vector of the frame.
- `S_AXIS_tready`, out, 1.
- `M_AXIS_tdata`, out, `OUTPUT_DMA_WIDTH`: to the DMA.
- `M_AXIS_tvalid`, out, 1.
- `M_AXIS_tlast`, out, 1.
- `M_AXIS_tready`, in, 1.
- `frame_done`, out, 1: one-cycle pulse after the frame's final output beat is transferred.

## Operation
- State is held in a holding register `buf` (CONV_UNITS words), a `last_q` flag, a beat index `idx` (0..BEATS-1) and a two-state FSM: IDLE and SEND.
- **IDLE:**
  - `S_AXIS_tready=1` and `M_AXIS_tvalid=0`.
  - On an S handshake: load `buf` and `last_q`, set `idx=0`, go to SEND.
- **SEND:**
  - `M_AXIS_tvalid=1`.
  - `M_AXIS_tdata` = `buf` words `idx*OUT_NUM .. idx*OUT_NUM+OUT_NUM-1`, with the lowest word in the LSBs.
  - `M_AXIS_tlast = last_q && idx==BEATS-1`.
  - On an M handshake with `idx<BEATS-1`: increment `idx`.
  - On an M handshake with `idx==BEATS-1`:
    - If an S handshake occurs in the same cycle: reload `buf`/`last_q`, set `idx=0`, stay in SEND (no bubble).
    - Otherwise: go to IDLE.
- `S_AXIS_tready = (state==IDLE) || (state==SEND && idx==BEATS-1 && M_AXIS_tready)`. This is the only combinational ready path.
- `frame_done` is registered and is 1 in the cycle after an M handshake with `M_AXIS_tlast=1`.
- `M_AXIS_tdata` and `M_AXIS_tlast` must not change while `M_AXIS_tvalid=1 && M_AXIS_tready=0`.
- `M_AXIS_tvalid` is never withdrawn before its handshake.

## Timing
- Reset values: state IDLE, `idx=0`, `last_q=0`, `M_AXIS_tvalid=0`, `M_AXIS_tlast=0`, `frame_done=0`. `S_AXIS_tready=1` from the first cycle after reset deasserts. `buf` is not reset; `M_AXIS_tdata` is don't-care while tvalid is 0.
- Latency: a vector accepted at edge N produces its first output beat valid in the cycle after edge N. With `M_AXIS_tready` held high, one output beat transfers per cycle.
- Sustained throughput: one input vector per BEATS cycles when `M_AXIS_tready=1`, with no idle cycles between vectors.
- Backpressure: with `M_AXIS_tready=0`, `idx` and `buf` freeze and `S_AXIS_tready=0` while in SEND.
- `BEATS==1`: `S_AXIS_tready` equals `M_AXIS_tready` while in SEND, giving a pass-through register stage.
- Reset mid-frame: held data and a partial frame are discarded. The block is in IDLE with tvalid 0 on the cycle after `areset` is sampled high. No `tlast` and no `frame_done` are emitted for the dropped frame.
- `S_AXIS_tlast` is sampled only on an S handshake.

## Configuration
- `OUTPUT_PIPE_RELU_EN` defined: each word is treated as two's complement and words with MSB=1 are replaced by 0. The clamp is applied when `buf` is loaded, so latency is unchanged.
- `OUTPUT_PIPE_RELU_EN` not defined: words pass through bit-exact.

## Test plan
All scenarios use defaults (OUT_NUM=4, BEATS=2) unless noted.
- **Single vector, tlast=1:** words 0..7, `M_AXIS_tready=1` -> beat 0 = words 0..3 with tlast=0, next cycle beat 1 = words 4..7 with tlast=1, `frame_done` pulses one cycle later, `S_AXIS_tready` is 0 during beat 0 only.
- **Streaming:** 4 vectors, the last one with tlast, source always valid, sink always ready -> 8 output beats on 8 consecutive cycles, tlast only on beat 8, exactly one `frame_done`.
- **Backpressure:** `M_AXIS_tready` toggles 1,0,0,1 -> tdata and tlast are stable during stalls, no beat is lost or duplicated, and the output sequence matches the in-order word stream.
- **Reset mid-frame:** assert `areset` after beat 0 of a tlast vector -> next cycle tvalid=0 and `S_AXIS_tready=1`; a new vector after reset emits correctly from its word 0.
- **RELU:** input words 0x8001, 0x7FFF, 0xFFFF, 0x0000 -> with `OUTPUT_PIPE_RELU_EN`: 0, 0x7FFF, 0, 0; without it: unchanged.
- **BEATS=1** (`OUTPUT_DMA_WIDTH=128`): vector every cycle with sink always ready -> one beat per cycle; holding `M_AXIS_tready` low drives `S_AXIS_tready` low in the same cycle.
